// File: rtl/shift_seq_ctrl_amisha_if.sv
// Client/shift-register bundle for the shift_seq_ctrl_amisha sequencer.
// The hold_amisha signal exists only when SHIFT_CTRL_HOLD_EN is defined.
interface shift_seq_ctrl_amisha_if #(
  parameter int N_amisha = 8
);
  logic                start_amisha;
  logic                mode_amisha;
  logic                dir_amisha;
  logic [N_amisha-1:0] din_amisha;
  logic                sin_amisha;
  logic [N_amisha-1:0] q_amisha;
  logic [1:0]          ctrl_amisha;
  logic [N_amisha-1:0] d_amisha;
  logic                sout_amisha;
  logic                busy_amisha;
  logic                done_amisha;
  logic [N_amisha-1:0] dout_amisha;
`ifdef SHIFT_CTRL_HOLD_EN
  logic                hold_amisha;
`endif

`ifdef SHIFT_CTRL_HOLD_EN
  modport slave (
    input  start_amisha, mode_amisha, dir_amisha, din_amisha, sin_amisha, q_amisha, hold_amisha,
    output ctrl_amisha, d_amisha, sout_amisha, busy_amisha, done_amisha, dout_amisha
  );

  modport master (
    output start_amisha, mode_amisha, dir_amisha, din_amisha, sin_amisha, q_amisha, hold_amisha,
    input  ctrl_amisha, d_amisha, sout_amisha, busy_amisha, done_amisha, dout_amisha
  );
`else
  modport slave (
    input  start_amisha, mode_amisha, dir_amisha, din_amisha, sin_amisha, q_amisha,
    output ctrl_amisha, d_amisha, sout_amisha, busy_amisha, done_amisha, dout_amisha
  );

  modport master (
    output start_amisha, mode_amisha, dir_amisha, din_amisha, sin_amisha, q_amisha,
    input  ctrl_amisha, d_amisha, sout_amisha, busy_amisha, done_amisha, dout_amisha
  );
`endif
endinterface

// File: rtl/shift_seq_ctrl_amisha.sv
// Word-transfer sequencer driving a universal shift register in TX (PISO) or RX (SIPO) mode.
// Optional feature macro SHIFT_CTRL_HOLD_EN adds hold_amisha, which pauses the SHIFT phase.
module shift_seq_ctrl_amisha #(
  parameter int N_amisha = 8
) (
  input  logic                   clk_amisha,
  input  logic                   reset_amisha,
  shift_seq_ctrl_amisha_if.slave bus
);

  localparam int CntW = $clog2(N_amisha);
  localparam logic [CntW-1:0] CntLast = CntW'(N_amisha - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [1:0] CtrlHold  = 2'b00;
  localparam logic [1:0] CtrlLeft  = 2'b01;
  localparam logic [1:0] CtrlRight = 2'b10;
  localparam logic [1:0] CtrlLoad  = 2'b11;

  logic [1:0]          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                mode_q, mode_d;
  logic                dir_q, dir_d;
  logic [N_amisha-1:0] din_q, din_d;
  logic [N_amisha-1:0] dout_q, dout_d;
  logic                holdActive;

`ifdef SHIFT_CTRL_HOLD_EN
  assign holdActive = bus.hold_amisha;
`else
  assign holdActive = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    din_d   = din_q;
    dout_d  = dout_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start_amisha) begin
          mode_d  = bus.mode_amisha;
          dir_d   = bus.dir_amisha;
          din_d   = bus.din_amisha;
          cnt_d   = '0;
          state_d = bus.mode_amisha ? StShift : StLoad;
        end
      end
      StLoad: begin
        state_d = StShift;
      end
      StShift: begin
        // A held cycle neither shifts nor counts, so it simply stretches the transfer.
        if (!holdActive) begin
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end
      StDone: begin
        if (mode_q) begin
          dout_d = bus.q_amisha;
        end
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      dir_q   <= 1'b0;
      din_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    bus.ctrl_amisha = CtrlHold;
    bus.d_amisha    = '0;
    unique case (state_q)
      StLoad: begin
        bus.ctrl_amisha = CtrlLoad;
        bus.d_amisha    = din_q;
      end
      StShift: begin
        // RX replicates sin so it enters at d[0] (left) or d[N-1] (right) alike.
        if (!holdActive) begin
          bus.ctrl_amisha = dir_q ? CtrlRight : CtrlLeft;
        end
        if (mode_q) begin
          bus.d_amisha = {N_amisha{bus.sin_amisha}};
        end
      end
      default: begin
        bus.ctrl_amisha = CtrlHold;
        bus.d_amisha    = '0;
      end
    endcase
  end

  assign bus.sout_amisha = dir_q ? bus.q_amisha[0] : bus.q_amisha[N_amisha-1];
  assign bus.busy_amisha = (state_q != StIdle);
  assign bus.done_amisha = (state_q == StDone);
  assign bus.dout_amisha = dout_q;

endmodule

// File: tb/tb_shift_seq_ctrl_amisha.sv
// Bench for shift_seq_ctrl_amisha with a behavioural universal shift register on q/ctrl/d.
// Covers table vectors, handshake/reset/hold corner cases and randomized transfers.
module tb_shift_seq_ctrl_amisha;

  localparam int N = 8;

  typedef struct {
    logic       start;
    logic       mode;
    logic       dir;
    logic [7:0] din;
    logic       sin;
    logic [1:0] ctrl;
    logic [7:0] d;
    logic       chkSout;
    logic       sout;
    logic       busy;
    logic       done;
    logic [7:0] dout;
  } vec_t;

  logic       clk_amisha = 1'b0;
  logic       reset_amisha;
  logic       holdDrive;
  logic [7:0] usrQ = 8'h00;
  logic [7:0] lastDout;
  int         total = 0;
  int         bad = 0;
  vec_t       vecs[$];

  shift_seq_ctrl_amisha_if #(.N_amisha(N)) bus ();

  shift_seq_ctrl_amisha #(.N_amisha(N)) dut (
    .clk_amisha   (clk_amisha),
    .reset_amisha (reset_amisha),
    .bus          (bus)
  );

  always #5 clk_amisha = ~clk_amisha;

  // Universal shift register the sequencer is meant to drive.
  always @(posedge clk_amisha) begin
    case (bus.ctrl_amisha)
      2'b01:   usrQ <= {usrQ[N-2:0], bus.d_amisha[0]};
      2'b10:   usrQ <= {bus.d_amisha[N-1], usrQ[N-1:1]};
      2'b11:   usrQ <= bus.d_amisha;
      default: usrQ <= usrQ;
    endcase
  end

  assign bus.q_amisha = usrQ;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(input logic start, input logic mode, input logic dir,
                              input logic [7:0] din, input logic sin, input logic [1:0] ctrl,
                              input logic [7:0] d, input logic chkSout, input logic sout,
                              input logic busy, input logic done, input logic [7:0] dout);
    vec_t v;
    v.start = start; v.mode = mode; v.dir = dir; v.din = din; v.sin = sin;
    v.ctrl = ctrl; v.d = d; v.chkSout = chkSout; v.sout = sout;
    v.busy = busy; v.done = done; v.dout = dout;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // One cycle: inputs change 1 time unit after the rising edge, outputs sampled 1 unit later.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk_amisha);
    #1;
    bus.start_amisha = v.start;
    bus.mode_amisha  = v.mode;
    bus.dir_amisha   = v.dir;
    bus.din_amisha   = v.din;
    bus.sin_amisha   = v.sin;
`ifdef SHIFT_CTRL_HOLD_EN
    bus.hold_amisha  = holdDrive;
`endif
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    check({tag, "_ctrl"}, 8'(bus.ctrl_amisha), 8'(v.ctrl));
    check({tag, "_d"}, bus.d_amisha, v.d);
    check({tag, "_busy"}, 8'(bus.busy_amisha), 8'(v.busy));
    check({tag, "_done"}, 8'(bus.done_amisha), 8'(v.done));
    check({tag, "_dout"}, bus.dout_amisha, v.dout);
    if (v.chkSout) check({tag, "_sout"}, 8'(bus.sout_amisha), 8'(v.sout));
  endtask

  // pat lists the expected sout bits, first bit at pat[7]; junk on inputs after accept.
  task automatic addTx(input logic dir, input logic [7:0] din, input logic [7:0] pat,
                       input logic [7:0] dout);
    vecs.push_back(mk(1, 0, dir, din, 0, 2'b00, 8'h00, 0, 0, 0, 0, dout));
    vecs.push_back(mk(0, 1, ~dir, ~din, 0, 2'b11, din, 0, 0, 1, 0, dout));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 1, ~dir, ~din, 0, dir ? 2'b10 : 2'b01, 8'h00, 1, pat[7-i], 1, 0, dout));
    vecs.push_back(mk(0, 1, ~dir, ~din, 0, 2'b00, 8'h00, 0, 0, 1, 1, dout));
  endtask

  task automatic addRx(input logic dir, input logic [7:0] bits, input logic [7:0] oldDout);
    logic s;
    vecs.push_back(mk(1, 1, dir, 8'h00, 0, 2'b00, 8'h00, 0, 0, 0, 0, oldDout));
    for (int i = 0; i < 8; i++) begin
      s = bits[7-i];
      vecs.push_back(mk(0, 0, ~dir, 8'hA5, s, dir ? 2'b10 : 2'b01, {8{s}}, 0, 0, 1, 0, oldDout));
    end
    vecs.push_back(mk(0, 0, ~dir, 8'h00, 0, 2'b00, 8'h00, 0, 0, 1, 1, oldDout));
  endtask

  initial begin
    vec_t v;
    vec_t idle;
    idle = mk(0, 0, 0, 8'h00, 0, 2'b00, 8'h00, 0, 0, 0, 0, 8'h00);
    holdDrive = 1'b0;
    reset_amisha = 1'b0;
    bus.start_amisha = 1'b0; bus.mode_amisha = 1'b0; bus.dir_amisha = 1'b0;
    bus.din_amisha = 8'h00; bus.sin_amisha = 1'b0;
`ifdef SHIFT_CTRL_HOLD_EN
    bus.hold_amisha = 1'b0;
`endif

    // Reset state.
    applyStimulus(idle);
    applyStimulus(idle);
    checkOutput(idle, "reset");
    reset_amisha = 1'b1;

    // Table-driven transfers.
    addTx(0, 8'h1E, 8'b0001_1110, 8'h00);
    addTx(1, 8'h1E, 8'b0111_1000, 8'h00);
    addRx(0, 8'b1100_1010, 8'h00);
    addRx(1, 8'b1100_1010, 8'hCA);
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 2'b00, 8'h00, 0, 0, 0, 0, 8'h53));
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("vec%0d", i));
    end

    // Start pulses during a TX transfer are ignored.
    applyStimulus(mk(1, 0, 0, 8'h1E, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int c = 1; c <= 12; c++) begin
      applyStimulus(mk((c == 3 || c == 9), 1, 1, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0));
      if (c == 4)  check("hs_ctrl_c4", 8'(bus.ctrl_amisha), 8'h01);
      if (c == 5)  check("hs_sout_c5", 8'(bus.sout_amisha), 8'h01);
      if (c == 10) check("hs_done_c10", 8'(bus.done_amisha), 8'h01);
      if (c == 11) check("hs_busy_c11", 8'(bus.busy_amisha), 8'h00);
      if (c == 12) check("hs_ctrl_c12", 8'(bus.ctrl_amisha), 8'h00);
    end

    // Start held high: back-to-back TX acceptance.
    for (int c = 0; c <= 22; c++) begin
      applyStimulus(mk((c <= 11), 0, 0, 8'h1E, 0, 0, 0, 0, 0, 0, 0, 0));
      if (c == 10) check("b2b_done_c10", 8'(bus.done_amisha), 8'h01);
      if (c == 11) check("b2b_busy_c11", 8'(bus.busy_amisha), 8'h00);
      if (c == 12) check("b2b_ctrl_c12", 8'(bus.ctrl_amisha), 8'h03);
      if (c == 12) check("b2b_d_c12", bus.d_amisha, 8'h1E);
      if (c == 21) check("b2b_done_c21", 8'(bus.done_amisha), 8'h01);
      if (c == 22) check("b2b_busy_c22", 8'(bus.busy_amisha), 8'h00);
    end

    // Reset asserted mid-transfer, then a fresh TX right of 8'h81.
    applyStimulus(mk(1, 0, 0, 8'h1E, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int c = 1; c <= 3; c++) applyStimulus(idle);
    check("rst_busy_pre", 8'(bus.busy_amisha), 8'h01);
    applyStimulus(idle);
    reset_amisha = 1'b0;
    #1;
    checkOutput(idle, "rst_mid");
    applyStimulus(idle);
    check("rst_done_held", 8'(bus.done_amisha), 8'h00);
    reset_amisha = 1'b1;
    applyStimulus(mk(1, 0, 1, 8'h81, 0, 0, 0, 0, 0, 0, 0, 0));
    check("rst_idle_after", 8'(bus.busy_amisha), 8'h00);
    applyStimulus(idle);
    check("rst_load_ctrl", 8'(bus.ctrl_amisha), 8'h03);
    check("rst_load_d", bus.d_amisha, 8'h81);
    for (int c = 2; c <= 10; c++) begin
      applyStimulus(idle);
      if (c <= 9) check($sformatf("rst_sout_c%0d", c), 8'(bus.sout_amisha), 8'((8'h81 >> (c - 2)) & 8'h01));
      check($sformatf("rst_done_c%0d", c), 8'(bus.done_amisha), 8'(c == 10));
    end
    lastDout = 8'h00;

`ifdef SHIFT_CTRL_HOLD_EN
    // Hold during TX cycles 5..7 freezes shifting and delays done to cycle 13.
    begin
      logic [7:0] pat;
      int b;
      pat = 8'b0001_1110;
      b = 0;
      applyStimulus(mk(1, 0, 0, 8'h1E, 0, 0, 0, 0, 0, 0, 0, lastDout));
      for (int c = 1; c <= 14; c++) begin
        holdDrive = (c >= 5 && c <= 7);
        applyStimulus(idle);
        if (c >= 2 && c <= 12) begin
          check($sformatf("hold_sout_c%0d", c), 8'(bus.sout_amisha), 8'(pat[7-b]));
          check($sformatf("hold_ctrl_c%0d", c), 8'(bus.ctrl_amisha), holdDrive ? 8'h00 : 8'h01);
          if (!holdDrive) b++;
        end
        check($sformatf("hold_done_c%0d", c), 8'(bus.done_amisha), 8'(c == 13));
      end
      holdDrive = 1'b0;
    end
`endif

    // Randomized transfers against a schedule derived from the transfer timing rules.
    for (int t = 0; t < 40; t++) begin
      logic       rm;
      logic       rd;
      logic       s;
      logic [7:0] rdin;
      logic [7:0] rbits;
      logic [7:0] word;
      int         len;
      int         g;
      rm = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      rdin = 8'($urandom);
      rbits = 8'($urandom);
      len = rm ? N + 1 : N + 2;
      v = mk(1, rm, rd, rdin, 0, 2'b00, 8'h00, 0, 0, 0, 0, lastDout);
      applyStimulus(v);
      checkOutput(v, "rand_idle");
      for (int c = 1; c <= len; c++) begin
        s = (rm && c <= N) ? rbits[c-1] : 1'($urandom_range(0, 1));
        v = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               8'($urandom), s, 2'b00, 8'h00, 0, 0, 1, 0, lastDout);
        if (c == len) begin
          v.done = 1'b1;
        end else if (!rm && c == 1) begin
          v.ctrl = 2'b11;
          v.d = rdin;
        end else begin
          v.ctrl = rd ? 2'b10 : 2'b01;
          if (rm) begin
            v.d = {8{s}};
          end else begin
            v.chkSout = 1'b1;
            v.sout = rd ? rdin[c-2] : rdin[N+1-c];
          end
        end
        applyStimulus(v);
        checkOutput(v, $sformatf("rand%0d_c%0d", t, c));
      end
      if (rm) begin
        word = 8'h00;
        for (int i = 0; i < N; i++) begin
          if (rd) word[i] = rbits[i];
          else    word[N-1-i] = rbits[i];
        end
        lastDout = word;
      end
      g = $urandom_range(0, 2);
      for (int k = 0; k < g; k++) begin
        v = mk(0, 0, 0, 8'h00, 0, 2'b00, 8'h00, 0, 0, 0, 0, lastDout);
        applyStimulus(v);
        checkOutput(v, "rand_gap");
      end
    end
    v = mk(0, 0, 0, 8'h00, 0, 2'b00, 8'h00, 0, 0, 0, 0, lastDout);
    applyStimulus(v);
    checkOutput(v, "rand_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
